// File: rtl/tile_pkg.sv
// tile_pkg: shared constants, tile/state enums, palette table and the
// procedural tile-art helper used by tile_rom.
//   MAP_W x MAP_H tile map, TILE_SZ-pixel square tiles, MAP_DEPTH map words.
package tile_pkg;

    localparam int MAP_W     = 40;
    localparam int MAP_H     = 30;
    localparam int TILE_SZ   = 16;
    localparam int MAP_DEPTH = 1200;
    localparam int LAT       = 4;

    typedef enum logic [2:0] {
        EMPTY = 3'd0,
        BRICK = 3'd1,
        STEEL = 3'd2,
        WATER = 3'd3,
        GRASS = 3'd4,
        ICE   = 3'd5,
        EAGLE = 3'd6,
        TEST  = 3'd7
    } tile_id_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } init_state_t;

    // Four RGB entries per tile id; index 0 of every tile is the backdrop.
    localparam logic [23:0] PALETTE [8][4] = '{
        '{24'h000000, 24'h000000, 24'h000000, 24'h000000},  // EMPTY
        '{24'h000000, 24'h9C4A00, 24'hD86800, 24'h5C2800},  // BRICK
        '{24'h000000, 24'hFFFFFF, 24'hA0A0A0, 24'h505050},  // STEEL
        '{24'h000000, 24'h2038EC, 24'h4080FF, 24'hA0C0FF},  // WATER
        '{24'h000000, 24'h00A800, 24'h58D854, 24'h005800},  // GRASS
        '{24'h000000, 24'hE0F8F8, 24'hB8E0F0, 24'h80C0E0},  // ICE
        '{24'h000000, 24'hF8D878, 24'hAC7C00, 24'h503000},  // EAGLE
        '{24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF}   // TEST
    };

    // Colour index of one texel. Tile 0 is blank; tile 7 is a 2x2 quadrant
    // test pattern indexed by {row[3], col[3]}; the rest are simple patterns.
    function automatic logic [1:0] tile_pixel(input logic [2:0] id,
                                              input logic [3:0] row,
                                              input logic [3:0] col);
        logic [1:0] idx;
        logic [3:0] shifted;
        idx     = 2'd0;
        shifted = col + (row[3] ? 4'd8 : 4'd0);
        case (id)
            3'd1:    idx = (row[2:0] == 3'd0 || shifted[2:0] == 3'd0) ? 2'd3 : 2'd1;
            3'd2:    idx = (row[2:0] == 3'd0 || col[2:0] == 3'd0) ? 2'd1 :
                           ((row[2:0] == 3'd7 || col[2:0] == 3'd7) ? 2'd3 : 2'd2);
            3'd3:    idx = (row[1:0] == col[1:0]) ? 2'd3 : 2'd1;
            3'd4:    idx = {row[0] ^ col[1], col[0]};
            3'd5:    idx = (row == col) ? 2'd1 : 2'd2;
            3'd6:    idx = (row[3] ^ row[2]) && (col[3] ^ col[2]) ? 2'd1 : 2'd0;
            3'd7:    idx = {row[3], col[3]};
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/tile_renderer_if.sv
// tile_renderer_if: timing-generator inputs, map write port and VGA outputs
// of the tile renderer.
//   master: drives hcs/vcs/syncs/enable and the map write port
//   slave : the renderer, drives init_busy, delayed syncs/enable and r/g/b
interface tile_renderer_if;
    logic [9:0]  hcs;
    logic [9:0]  vcs;
    logic        hsync_in;
    logic        vsync_in;
    logic        disp_ena_in;
    logic        map_we;
    logic [10:0] map_waddr;
    logic [2:0]  map_wdata;
    logic        init_busy;
    logic        hsync_out;
    logic        vsync_out;
    logic        disp_ena_out;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;

    modport master (
        output hcs, vcs, hsync_in, vsync_in, disp_ena_in,
        output map_we, map_waddr, map_wdata,
        input  init_busy, hsync_out, vsync_out, disp_ena_out, r, g, b
    );

    modport slave (
        input  hcs, vcs, hsync_in, vsync_in, disp_ena_in,
        input  map_we, map_waddr, map_wdata,
        output init_busy, hsync_out, vsync_out, disp_ena_out, r, g, b
    );
endinterface

// File: rtl/tile_rom.sv
// tile_rom: 2048x2 tile texture ROM with a one-cycle registered read.
//   clk25 : pixel clock
//   addr  : {tile_id[2:0], row[3:0], col[3:0]}
//   idx   : 2-bit palette index, valid the cycle after addr
module tile_rom
    import tile_pkg::*;
(
    input  logic        clk25,
    input  logic [10:0] addr,
    output logic [1:0]  idx
);

    // Registered texel lookup; content is generated by tile_pixel.
    always_ff @(posedge clk25) begin
        idx <= tile_pixel(addr[10:8], addr[7:4], addr[3:0]);
    end

endmodule

// File: rtl/tile_renderer.sv
// tile_renderer: four-stage pixel colour pipeline behind a 640x480 VGA
// timing generator, with a 40x30 tile map cleared by an INIT sequencer.
//   clk25   : pixel clock
//   reset_n : synchronous active-low reset
//   bus     : timing inputs, map write port, init_busy, delayed syncs,
//             delayed display enable and 8-bit r/g/b (all outputs 4 cycles
//             after the inputs that produced them)
module tile_renderer
    import tile_pkg::*;
(
    input  logic             clk25,
    input  logic             reset_n,
    tile_renderer_if.slave   bus
);

    init_state_t state, state_nx;
    logic [10:0] clr_cnt, clr_cnt_nx;

    logic        wr_en;
    logic [10:0] wr_addr;
    tile_id_t    wr_data;

    tile_id_t    map_mem [MAP_DEPTH];

    logic [10:0] map_raddr;
    logic [3:0]  row0, col0, row1, col1;
    tile_id_t    tile1, tile2;
    logic [1:0]  idx2;
    logic [3:0]  hs_pipe, vs_pipe, de_pipe;
    logic [23:0] rgb;
    logic [10:0] row_base;

    assign row_base = {5'd0, bus.vcs[9:4]} * 11'd40;

    // Init sequencer state and clear counter.
    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            state   <= INIT;
            clr_cnt <= 11'd0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
        end
    end

    // Init sequencer next state: sweep every map word, then hand over.
    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        case (state)
            INIT: begin
                if (clr_cnt == 11'(MAP_DEPTH - 1)) begin
                    state_nx   = RUN;
                    clr_cnt_nx = 11'd0;
                end else begin
                    clr_cnt_nx = clr_cnt + 11'd1;
                end
            end
            RUN: begin
                state_nx = RUN;
            end
            default: begin
                state_nx   = INIT;
                clr_cnt_nx = 11'd0;
            end
        endcase
    end

    // Single map write port: the clear sweep owns it during INIT, game logic
    // afterwards; out-of-range game writes are dropped.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = 11'd0;
        wr_data = EMPTY;
        if (state == INIT) begin
            wr_en   = 1'b1;
            wr_addr = clr_cnt;
            wr_data = EMPTY;
        end else if (bus.map_we && (bus.map_waddr < 11'(MAP_DEPTH))) begin
            wr_en   = 1'b1;
            wr_addr = bus.map_waddr;
            wr_data = tile_id_t'(bus.map_wdata);
        end else begin
            wr_en   = 1'b0;
        end
    end

    // Map RAM write; the read below sees the old word on a collision.
    always_ff @(posedge clk25) begin
        if (wr_en) begin
            map_mem[wr_addr] <= wr_data;
        end
    end

    // Map RAM read (S1), no reset so it maps onto block RAM.
    always_ff @(posedge clk25) begin
        tile1 <= map_mem[map_raddr];
    end

    // S0..S2 address/offset registers and the sync/enable delay line.
    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            map_raddr <= 11'd0;
            row0      <= 4'd0;
            col0      <= 4'd0;
            row1      <= 4'd0;
            col1      <= 4'd0;
            tile2     <= EMPTY;
            hs_pipe   <= 4'b1111;
            vs_pipe   <= 4'b1111;
            de_pipe   <= 4'b0000;
        end else begin
            map_raddr <= row_base + {5'd0, bus.hcs[9:4]};
            row0      <= bus.vcs[3:0];
            col0      <= bus.hcs[3:0];
            row1      <= row0;
            col1      <= col0;
            tile2     <= tile1;
            hs_pipe   <= {hs_pipe[2:0], bus.hsync_in};
            vs_pipe   <= {vs_pipe[2:0], bus.vsync_in};
            de_pipe   <= {de_pipe[2:0], bus.disp_ena_in};
        end
    end

    tile_rom u_rom (
        .clk25 (clk25),
        .addr  ({tile1, row1, col1}),
        .idx   (idx2)
    );

    // S3 palette lookup; blanked whenever the aligned enable is low.
    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            rgb <= 24'h000000;
        end else if (de_pipe[2]) begin
            rgb <= PALETTE[tile2][idx2];
        end else begin
            rgb <= 24'h000000;
        end
    end

    assign bus.init_busy    = (state == INIT);
    assign bus.hsync_out    = hs_pipe[3];
    assign bus.vsync_out    = vs_pipe[3];
    assign bus.disp_ena_out = de_pipe[3];
    assign bus.r            = rgb[23:16];
    assign bus.g            = rgb[15:8];
    assign bus.b            = rgb[7:0];

endmodule

// File: tb/tb_tile_renderer.sv
// Testbench for tile_renderer: directed pixel vectors push expected outputs
// into a queue; a monitor pops and compares when the delayed tag arrives.
module tb_tile_renderer;

    localparam logic [23:0] BLACK = 24'h000000;
    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] GREEN = 24'h00FF00;
    localparam logic [23:0] BLUE  = 24'h0000FF;

    typedef struct {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
        string       tag;
    } exp_t;

    logic clk25 = 1'b0;
    logic reset_n;
    always #20 clk25 = ~clk25;

    tile_renderer_if bus();

    tile_renderer dut (
        .clk25   (clk25),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    logic chk_in = 1'b0;
    logic [3:0] chk_pipe = 4'd0;

    // Tag that travels alongside the DUT pipeline.
    always @(posedge clk25) begin
        if (!reset_n) chk_pipe <= 4'd0;
        else          chk_pipe <= {chk_pipe[2:0], chk_in};
    end

    // Monitor: compare DUT outputs against the oldest expected entry.
    always @(negedge clk25) begin
        if (chk_pipe[3]) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_underflow: output tagged but no expectation queued");
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({bus.r, bus.g, bus.b} !== e.rgb || bus.hsync_out !== e.hs ||
                    bus.vsync_out !== e.vs || bus.disp_ena_out !== e.de) begin
                    n_bad++;
                    $display("FAIL %s: got rgb=%06h hs=%b vs=%b de=%b, want rgb=%06h hs=%b vs=%b de=%b",
                             e.tag, {bus.r, bus.g, bus.b}, bus.hsync_out, bus.vsync_out,
                             bus.disp_ena_out, e.rgb, e.hs, e.vs, e.de);
                end
            end
        end
    end

    task automatic check1(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, req);
        end
    endtask

    // Present one pixel for one cycle; optionally queue its expected output.
    task automatic drive(input int h, input int v, input logic hs, input logic vs,
                         input logic de, input logic chk, input logic [23:0] rgb,
                         input string tag);
        exp_t e;
        bus.hcs         = 10'(h);
        bus.vcs         = 10'(v);
        bus.hsync_in    = hs;
        bus.vsync_in    = vs;
        bus.disp_ena_in = de;
        chk_in          = chk;
        if (chk) begin
            e.rgb = de ? rgb : BLACK;
            e.hs  = hs;
            e.vs  = vs;
            e.de  = de;
            e.tag = tag;
            q.push_back(e);
        end
        @(negedge clk25);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, BLACK, "idle");
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_rgb"}, {8'd0, bus.r, bus.g, bus.b}, 32'd0);
        check1({tag, "_hsync"}, {31'd0, bus.hsync_out}, 32'd1);
        check1({tag, "_vsync"}, {31'd0, bus.vsync_out}, 32'd1);
        check1({tag, "_de"}, {31'd0, bus.disp_ena_out}, 32'd0);
        check1({tag, "_busy"}, {31'd0, bus.init_busy}, 32'd1);
    endtask

    // Count cycles with init_busy high; pokes the map and samples address 0
    // while the clear sweep is running.
    task automatic run_init(input string tag);
        int cycles;
        cycles = 0;
        while (bus.init_busy === 1'b1 && cycles < 2000) begin
            cycles++;
            bus.map_we    = (cycles == 10);
            bus.map_waddr = 11'd0;
            bus.map_wdata = 3'd7;
            if (cycles >= 20 && cycles < 24)
                drive(8 + cycles - 20, 8, 1'b1, 1'b1, 1'b1, 1'b1, BLACK, {tag, "_pix"});
            else
                drive(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, BLACK, "idle");
        end
        bus.map_we = 1'b0;
        check1({tag, "_len"}, cycles, 32'd1200);
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.map_we    = 1'b0;
        bus.map_waddr = 11'd0;
        bus.map_wdata = 3'd0;
        drive(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, BLACK, "idle");
        idle(4);
        check_reset_outputs("por");
        reset_n = 1'b1;
        run_init("init");
        idle(6);

        // Place the test tile at row 1, col 1.
        bus.map_we = 1'b1; bus.map_waddr = 11'd41; bus.map_wdata = 3'd7;
        idle(1);
        bus.map_we = 1'b0;
        idle(1);
        drive(16, 16, 1'b1, 1'b1, 1'b1, 1'b1, BLACK, "t7_q00");
        drive(24, 16, 1'b1, 1'b1, 1'b1, 1'b1, RED,   "t7_q01");
        drive(16, 24, 1'b1, 1'b1, 1'b1, 1'b1, GREEN, "t7_q10");
        drive(31, 31, 1'b1, 1'b1, 1'b1, 1'b1, BLUE,  "t7_q11");
        drive(23, 23, 1'b1, 1'b1, 1'b1, 1'b1, BLACK, "t7_edge");
        drive(24, 16, 1'b1, 1'b1, 1'b0, 1'b1, BLACK, "de_blank");
        drive(40, 16, 1'b1, 1'b1, 1'b1, 1'b1, BLACK, "tile42");
        drive(8,  8,  1'b1, 1'b1, 1'b1, 1'b1, BLACK, "init_we_ignored");
        drive(24, 16, 1'b0, 1'b0, 1'b1, 1'b1, RED,   "sync_with_red");

        // Horizontal blanking and sync edge.
        for (int h = 636; h < 664; h++)
            drive(h, 24, !(h >= 656 && h < 752), 1'b1, (h < 640), 1'b1, BLACK, "hblank");
        drive(799, 24, 1'b1, 1'b1, 1'b0, 1'b1, BLACK, "hblank_end");
        drive(700, 490, 1'b1, 1'b0, 1'b0, 1'b1, BLACK, "vsync");
        idle(6);

        // Out-of-range write must not touch the map.
        bus.map_we = 1'b1; bus.map_waddr = 11'd1200; bus.map_wdata = 3'd7;
        idle(1);
        bus.map_we = 1'b0;
        idle(1);
        drive(8,   8,   1'b1, 1'b1, 1'b1, 1'b1, BLACK, "oor_addr0");
        drive(632, 472, 1'b1, 1'b1, 1'b1, 1'b1, BLACK, "oor_addr1199");
        drive(24,  16,  1'b1, 1'b1, 1'b1, 1'b1, RED,   "oor_addr41");

        // Write address 0 in the same cycle S1 reads it.
        drive(8, 8, 1'b1, 1'b1, 1'b1, 1'b1, BLACK, "coll_old");
        bus.map_we = 1'b1; bus.map_waddr = 11'd0; bus.map_wdata = 3'd7;
        drive(9, 9, 1'b1, 1'b1, 1'b1, 1'b1, BLUE, "coll_next");
        bus.map_we = 1'b0;
        drive(8, 8, 1'b1, 1'b1, 1'b1, 1'b1, BLUE, "coll_new");
        idle(6);

        // Mid-frame reset with non-idle outputs in flight.
        for (int i = 0; i < 5; i++)
            drive(24, 16, 1'b0, 1'b0, 1'b1, 1'b0, BLACK, "prefill");
        check1("prefill_red", {8'd0, bus.r, bus.g, bus.b}, {8'd0, RED});
        reset_n = 1'b0;
        drive(100, 200, 1'b1, 1'b1, 1'b1, 1'b0, BLACK, "reset_pix");
        check_reset_outputs("midreset");
        reset_n = 1'b1;
        run_init("reinit");
        idle(6);
        drive(24, 16, 1'b1, 1'b1, 1'b1, 1'b1, BLACK, "cleared_addr41");
        drive(9,  9,  1'b1, 1'b1, 1'b1, 1'b1, BLACK, "cleared_addr0");
        idle(6);

        check1("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
